// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial program image loader for the instruction memory
// Parses a big-endian word count and big-endian words, writes them sequentially, then releases the CPU.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        WAIT_HI = 3'd0,
        WAIT_LO = 3'd1,
        COLLECT = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              xfer;
    logic [15:0]       n_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_HI;
            n_q     <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            wl_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            wl_q    <= wl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Handshake is decoded purely from state so in_ready never depends on in_valid.
    assign in_ready = (state_q == WAIT_HI) || (state_q == WAIT_LO) || (state_q == COLLECT);
    assign xfer     = in_valid && in_ready;
    assign n_full   = {n_q[15:8], in_data};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        word_d  = word_q;
        idx_d   = idx_q;
        wl_d    = wl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            WAIT_HI: begin
                if (xfer) begin
                    n_d[15:8] = in_data;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (xfer) begin
                    n_d[7:0] = in_data;
                    if (n_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, n_full} > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    word_d = {word_q[23:0], in_data};
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        addr_d  = wl_q[ADDR_W-1:0];
                        wdata_d = word_d;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                wl_d = wl_q + {{ADDR_W{1'b0}}, 1'b1};
                if ({{(16 - ADDR_W){1'b0}}, wl_d} == {1'b0, n_q}) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            DONE, ERR: begin
                if (restart) begin
                    state_d = WAIT_HI;
                    wl_d    = '0;
                    idx_d   = 2'd0;
                end
            end
            default: begin
                state_d = WAIT_HI;
            end
        endcase
    end

    assign imem_we      = (state_q == WRITE);
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);
    assign words_loaded = wl_q;

endmodule
